// File: rtl/axi4_lite_fifo_drain_master_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_fifo_drain_master_if
//   Groups the AXI4-Lite read channel (AR + R) toward the async FIFO slave and
//   the valid/ready output stream toward the peripheral datapath.
//
//   Modports:
//     master : the drain master (drives AR request, RREADY, output stream)
//     slave  : the environment (FIFO slave read port + downstream consumer)
//
//   Signals:
//     M_AXI_ARADDR  [ADDR_WIDTH]  read address
//     M_AXI_ARVALID / M_AXI_ARREADY  AR handshake
//     M_AXI_RDATA   [DATA_WIDTH]  read data
//     M_AXI_RRESP   [2]           read response
//     M_AXI_RVALID / M_AXI_RREADY    R handshake
//     out_data      [DATA_WIDTH]  drained word
//     out_valid / out_ready          output stream handshake
// ----------------------------------------------------------------------------
interface axi4_lite_fifo_drain_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  out_data, out_valid,
        output out_ready
    );
endinterface

// File: rtl/axi4_lite_fifo_drain_master.sv
// ----------------------------------------------------------------------------
// axi4_lite_fifo_drain_master
//   AXI4-Lite read-only initiator. Repeatedly reads a fixed FIFO address,
//   forwards OKAY data on a valid/ready stream and, on any non-OKAY response
//   (SLVERR = FIFO empty), waits BACKOFF_CYCLES idle cycles before polling
//   again. One outstanding request at a time.
//
//   Ports:
//     rd_clk         clock for all logic
//     S_AXI_ARESETN  asynchronous, active-low reset (release is synchronous
//                    to rd_clk by the surrounding reset tree)
//     enable         allows a new AR; only looked at in IDLE
//     bus            AXI read channel + output stream (master modport)
//     busy           high whenever the FSM is not in IDLE
//     err_resp       one-cycle pulse for every non-OKAY RRESP
//     stat_words     (AXI4_LITE_DRAIN_STATS_EN only) output handshakes, wraps
//     stat_errs      (AXI4_LITE_DRAIN_STATS_EN only) non-OKAY responses, wraps
//
//   Optional feature macro: AXI4_LITE_DRAIN_STATS_EN
//
//   BACKOFF_CYCLES must be >= 1. The FSM spends exactly BACKOFF_CYCLES cycles
//   in BACKOFF after an error response, then one IDLE cycle before the next AR.
// ----------------------------------------------------------------------------
module axi4_lite_fifo_drain_master #(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RD_ADDR        = '0,
    parameter int                    BACKOFF_CYCLES = 16
) (
    input  logic                              rd_clk,
    input  logic                              S_AXI_ARESETN,
    input  logic                              enable,
    axi4_lite_fifo_drain_master_if.master     bus,
    output logic                              busy,
    output logic                              err_resp
`ifdef AXI4_LITE_DRAIN_STATS_EN
    ,
    output logic [31:0]                       stat_words,
    output logic [15:0]                       stat_errs
`endif
);

    localparam int CNT_W = $clog2(BACKOFF_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_PUSH,
        S_BACKOFF
    } state_t;

    state_t                state_q, state_nxt;
    logic                  arvalid_q, arvalid_nxt;
    logic                  rready_q, rready_nxt;
    logic                  out_valid_q, out_valid_nxt;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  err_nxt;
    logic                  out_hs;

    assign out_hs = out_valid_q && bus.out_ready;

    // Next-state and next-output logic. Every output is a register, so the
    // handshake outputs are computed one cycle ahead here.
    always_comb begin
        state_nxt     = state_q;
        arvalid_nxt   = arvalid_q;
        rready_nxt    = rready_q;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        cnt_nxt       = cnt_q;
        err_nxt       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    arvalid_nxt = 1'b1;
                    state_nxt   = S_AR;
                end
            end
            S_AR: begin
                // ARVALID drops in the same edge as the handshake, so a slave
                // parking ARREADY high never sees a second request.
                if (arvalid_q && bus.M_AXI_ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_R;
                end
            end
            S_R: begin
                if (rready_q && bus.M_AXI_RVALID) begin
                    rready_nxt = 1'b0;
                    if (bus.M_AXI_RRESP == 2'b00) begin
                        out_data_nxt  = bus.M_AXI_RDATA;
                        out_valid_nxt = 1'b1;
                        state_nxt     = S_PUSH;
                    end else begin
                        // Any non-OKAY response is treated as "FIFO empty".
                        err_nxt   = 1'b1;
                        cnt_nxt   = CNT_W'(BACKOFF_CYCLES - 1);
                        state_nxt = S_BACKOFF;
                    end
                end
            end
            S_PUSH: begin
                if (out_hs) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (cnt_q == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                arvalid_nxt   = 1'b0;
                rready_nxt    = 1'b0;
                out_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            arvalid_q   <= arvalid_nxt;
            rready_q    <= rready_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            cnt_q       <= cnt_nxt;
            busy        <= (state_nxt != S_IDLE);
            err_resp    <= err_nxt;
        end
    end

`ifdef AXI4_LITE_DRAIN_STATS_EN
    always_ff @(posedge rd_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            stat_words <= '0;
            stat_errs  <= '0;
        end else begin
            if (out_hs)  stat_words <= stat_words + 32'd1;
            if (err_nxt) stat_errs  <= stat_errs + 16'd1;
        end
    end
`endif

    assign bus.M_AXI_ARADDR  = RD_ADDR;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_RREADY  = rready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;

endmodule

// File: tb/tb_axi4_lite_fifo_drain_master.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_fifo_drain_master
//   Self-checking bench. The bench plays the FIFO slave and the downstream
//   consumer, and keeps a transaction-level reference: which phase of a read
//   is open, what word must be on the stream, when the post-error quiet time
//   ends. Every negedge the DUT outputs are compared against that reference.
// ----------------------------------------------------------------------------
module tb_axi4_lite_fifo_drain_master;
    localparam int             AW = 4;
    localparam int             DW = 32;
    localparam int             B  = 16;
    localparam logic [AW-1:0]  RD = 4'hA;

    logic rd_clk = 1'b0;
    logic S_AXI_ARESETN;
    logic enable;
    logic busy;
    logic err_resp;
`ifdef AXI4_LITE_DRAIN_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_errs;
`endif

    axi4_lite_fifo_drain_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_fifo_drain_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_ADDR(RD), .BACKOFF_CYCLES(B)
    ) dut (
        .rd_clk(rd_clk),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .enable(enable),
        .bus(bus),
        .busy(busy),
        .err_resp(err_resp)
`ifdef AXI4_LITE_DRAIN_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_errs(stat_errs)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int ncmp, nerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---- reference: phases of the single outstanding read ----
    typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } beat_t;
    bit            m_busy, m_ar, m_r, m_out, m_wait, m_err;
    logic [DW-1:0] m_data;
    int            wait_until, cyc, words_m, errs_m;
    beat_t         dir_q[$];
    beat_t         cur;

    // ---- slave / consumer knobs ----
    int ar_cnt, ar_dly, r_cnt, r_dly;
    int en_pct, or_pct, ar_fix, r_fix;
    bit ar_always;

    task automatic model_reset();
        m_busy = 0; m_ar = 0; m_r = 0; m_out = 0; m_wait = 0; m_err = 0;
        m_data = '0; wait_until = 0; words_m = 0; errs_m = 0;
        ar_cnt = 0; r_cnt = 0; ar_dly = 0; r_dly = 0;
        dir_q.delete();
    endtask

    task automatic knobs(input int en, input int orp, input int arf, input int rf, input bit aa);
        en_pct = en; or_pct = orp; ar_fix = arf; r_fix = rf; ar_always = aa;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        int    k;
        b.data = $urandom;
        k = $urandom_range(0, 9);
        b.resp = (k < 6) ? 2'b00 : (k < 8) ? 2'b10 : (k == 8) ? 2'b01 : 2'b11;
        return b;
    endfunction

    // One clock cycle, entered and left at a negedge.
    task automatic cycle();
        int p;
        chk("araddr", bus.M_AXI_ARADDR, RD);
        chk("arvalid", bus.M_AXI_ARVALID, m_ar);
        chk("rready", bus.M_AXI_RREADY, m_r);
        chk("out_valid", bus.out_valid, m_out);
        if (m_out) chk("out_data", bus.out_data, m_data);
        chk("busy", busy, m_busy);
        chk("err_resp", err_resp, m_err);
`ifdef AXI4_LITE_DRAIN_STATS_EN
        chk("stat_words", stat_words, 32'(words_m));
        chk("stat_errs", stat_errs, 16'(errs_m));
`endif
        // drive
        enable            = ($urandom_range(0, 99) < en_pct);
        bus.M_AXI_ARREADY = m_ar ? (ar_cnt >= ar_dly) : ar_always;
        bus.M_AXI_RVALID  = m_r && (r_cnt >= r_dly);
        if (bus.M_AXI_RVALID) begin
            bus.M_AXI_RDATA = cur.data;
            bus.M_AXI_RRESP = cur.resp;
        end else begin
            bus.M_AXI_RDATA = $urandom;
            bus.M_AXI_RRESP = 2'($urandom_range(0, 3));
        end
        bus.out_ready = ($urandom_range(0, 99) < or_pct);
        // reference update for the coming edge
        p = cyc + 1;
        m_err = 0;
        if (!m_busy) begin
            if (enable) begin
                m_busy = 1; m_ar = 1; ar_cnt = 0;
                ar_dly = (ar_fix >= 0) ? ar_fix : $urandom_range(0, 3);
            end
        end else if (m_ar) begin
            if (bus.M_AXI_ARREADY) begin
                m_ar = 0; m_r = 1; r_cnt = 0;
                cur = (dir_q.size() != 0) ? dir_q.pop_front() : rand_beat();
                r_dly = (r_fix >= 0) ? r_fix : $urandom_range(0, 4);
            end else ar_cnt++;
        end else if (m_r) begin
            if (bus.M_AXI_RVALID) begin
                m_r = 0;
                if (cur.resp == 2'b00) begin
                    m_out = 1; m_data = cur.data;
                end else begin
                    m_err = 1; m_wait = 1; wait_until = p + B; errs_m++;
                end
            end else r_cnt++;
        end else if (m_out) begin
            if (bus.out_ready) begin
                m_out = 0; m_busy = 0; words_m++;
            end
        end else if (m_wait) begin
            if (p == wait_until) begin
                m_wait = 0; m_busy = 0;
            end
        end
        cyc = p;
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    task automatic wait_counts(input int tw, input int te, input int limit);
        int n = 0;
        while ((words_m < tw || errs_m < te) && n < limit) begin
            cycle();
            n++;
        end
    endtask

    task automatic wait_phase(input bit want_out, input int limit);
        int n = 0;
        while (!(want_out ? m_out : m_r) && n < limit) begin
            cycle();
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        en_pct = 0; or_pct = 100;
        while (m_busy && n < 200) begin
            cycle();
            n++;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_araddr", bus.M_AXI_ARADDR, RD);
        chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
        chk("rst_rready", bus.M_AXI_RREADY, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_resp", err_resp, 0);
`ifdef AXI4_LITE_DRAIN_STATS_EN
        chk("rst_stat_words", stat_words, 0);
        chk("rst_stat_errs", stat_errs, 0);
`endif
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic mid_reset();
        #2 S_AXI_ARESETN = 1'b0;
        #1;
        chk("arst_arvalid", bus.M_AXI_ARVALID, 0);
        chk("arst_rready", bus.M_AXI_RREADY, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", busy, 0);
        @(posedge rd_clk);
        @(negedge rd_clk);
        check_reset_vals();
        S_AXI_ARESETN = 1'b1;
        model_reset();
    endtask

    initial begin
        ncmp = 0; nerr = 0; cyc = 0;
        S_AXI_ARESETN = 1'b0; enable = 1'b0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = '0;
        bus.M_AXI_RRESP = 2'b00; bus.out_ready = 0;
        model_reset();
        knobs(0, 100, 0, 0, 1);
        repeat (3) @(negedge rd_clk);
        check_reset_vals();
        S_AXI_ARESETN = 1'b1;

        // 1: single OKAY read, ARREADY parked high
        knobs(100, 100, 0, 0, 1);
        dir_q.push_back(beat_t'{32'hDEADBEEF, 2'b00});
        wait_counts(1, 0, 50);
        en_pct = 0;
        repeat (5) cycle();

        // 2: SLVERR then backoff; the next request must wait out the quiet time
        knobs(100, 100, 0, 0, 1);
        dir_q.push_back(beat_t'{32'h12345678, 2'b10});
        dir_q.push_back(beat_t'{32'h0000CAFE, 2'b00});
        wait_counts(1, 1, 80);
        drain();

        // 3: downstream back-pressure for 10 cycles
        knobs(100, 0, 0, 0, 0);
        dir_q.push_back(beat_t'{32'h00000005, 2'b00});
        wait_phase(1'b1, 50);
        repeat (10) cycle();
        or_pct = 100;
        wait_counts(1, 0, 20);
        drain();

        // 4: slow slave, 8 words streamed in order
        model_reset();
        mid_reset();
        knobs(100, 100, 3, 5, 0);
        for (int i = 1; i <= 8; i++) dir_q.push_back(beat_t'{DW'(i), 2'b00});
        wait_counts(8, 0, 200);
        drain();

        // 5: reset in R, reset in PUSH, then a clean transaction
        knobs(100, 100, 0, 50, 1);
        wait_phase(1'b0, 50);
        repeat (3) cycle();
        mid_reset();
        knobs(100, 0, 0, 0, 1);
        wait_phase(1'b1, 50);
        repeat (2) cycle();
        mid_reset();
        knobs(100, 100, 0, 0, 1);
        dir_q.push_back(beat_t'{32'h0BADF00D, 2'b00});
        wait_counts(1, 0, 50);
        drain();

        // 6: 5 OKAY + 3 SLVERR from reset
        mid_reset();
        knobs(100, 100, 1, 1, 0);
        dir_q.push_back(beat_t'{32'h11, 2'b00});
        dir_q.push_back(beat_t'{32'h22, 2'b10});
        dir_q.push_back(beat_t'{32'h33, 2'b00});
        dir_q.push_back(beat_t'{32'h44, 2'b10});
        dir_q.push_back(beat_t'{32'h55, 2'b00});
        dir_q.push_back(beat_t'{32'h66, 2'b00});
        dir_q.push_back(beat_t'{32'h77, 2'b10});
        dir_q.push_back(beat_t'{32'h88, 2'b00});
        wait_counts(5, 3, 400);
        drain();
`ifdef AXI4_LITE_DRAIN_STATS_EN
        chk("stats_words_5", stat_words, 5);
        chk("stats_errs_3", stat_errs, 3);
`endif

        // random traffic
        for (int s = 0; s < 40; s++) begin
            knobs(($urandom_range(0, 1) != 0) ? 100 : 70,
                  ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) != 0) ? 100 : 50),
                  -1, -1, 1'($urandom_range(0, 1)));
            repeat (60) cycle();
        end
        drain();
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/axi4_lite_fifo_drain_master.md
Name: axi4_lite_fifo_drain_master

Overview:
- AXI4-Lite read-only initiator on rd_clk. It drains words from the async FIFO slave's read channel and forwards them on a valid/ready output stream to the peripheral.
- Issues one AR at a time to a fixed FIFO address and accepts the R beat.
- OKAY data is pushed downstream. SLVERR (FIFO empty) triggers a programmable backoff before re-polling.
- Sits between the FIFO slave's read port and the peripheral datapath.

Parameters:
- ADDR_WIDTH, 4, AR address width.
- DATA_WIDTH, 32, data width of R and of the output stream.
- RD_ADDR, 0, constant ARADDR driven on every request.
- BACKOFF_CYCLES, 16, idle cycles after an SLVERR before the next AR. Must be >= 1.

Ports:
- rd_clk  in  1  clock for all logic.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- enable  in  1  allows new AR issue. Sampled only in IDLE.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address, constant RD_ADDR.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- out_data  out  DATA_WIDTH  drained word.
- out_valid  out  1  drained word valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state != IDLE.
- err_resp  out  1  one-cycle pulse on any non-OKAY RRESP.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, M_AXI_ARVALID=0, M_AXI_RREADY=0.
  - out_valid=0, out_data=0, busy=0, err_resp=0, backoff counter=0.
  - M_AXI_ARADDR is always RD_ADDR.
- All outputs are registered. Reset mid-transaction drops ARVALID, RREADY and out_valid immediately, with no completion.
- FSM states:
  - IDLE: if enable, set ARVALID<=1 and go to AR. Otherwise stay.
  - AR: hold ARVALID=1, address stable. On ARVALID&&ARREADY, set ARVALID<=0 and RREADY<=1, go to R. Exactly one AR handshake per transaction. A slave holding ARREADY=1 continuously must not see a second request.
  - R: RREADY=1. On RVALID&&RREADY, set RREADY<=0.
    - RRESP==2'b00: set out_data<=RDATA, out_valid<=1, go to PUSH.
    - RRESP!=00 (SLVERR=2'b10 means empty; 01 and 11 are treated the same): pulse err_resp, load counter=BACKOFF_CYCLES-1, go to BACKOFF. Data is discarded.
  - PUSH: hold out_valid and out_data stable until out_ready. On out_valid&&out_ready, set out_valid<=0 and go to IDLE.
  - BACKOFF: decrement the counter each cycle. At 0, go to IDLE.
- R beats are accepted only in R state, and RREADY is never high outside R. An RVALID that arrives in the same cycle as AR acceptance is taken on the following cycle, because the slave holds RVALID until RREADY.
- Throughput: best case one word per 4 cycles (IDLE, AR, R, PUSH with out_ready=1).
- enable deassertion mid-transaction does not abort. The current transaction completes, then the FSM stays in IDLE.
- Counter width is $clog2(BACKOFF_CYCLES)+1. BACKOFF_CYCLES=1 gives a single BACKOFF cycle.

Optional Feature:
- Macro: AXI4_LITE_DRAIN_STATS_EN.
- With the macro defined, two extra outputs are present:
  - stat_words (32 bits): increments on each out handshake.
  - stat_errs (16 bits): increments on each non-OKAY RRESP.
  - Both reset to 0, wrap modulo 2^N, and update one cycle after the event.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset then enable=1, slave with ARREADY=1 returns RDATA=0xDEADBEEF, RRESP=00, out_ready=1 -> exactly one AR handshake, then out_valid=1 with out_data=0xDEADBEEF, then IDLE. ARADDR==RD_ADDR throughout.
2. Slave returns RRESP=2'b10 with BACKOFF_CYCLES=16 -> err_resp pulses once. No out_valid. Next ARVALID rises no earlier than 16 cycles after the R handshake.
3. Back-pressure: out_ready=0 for 10 cycles after a 0x00000005 read -> out_valid and out_data stay stable and no new AR is issued. Releasing out_ready gives exactly one transfer.
4. Slave delays ARREADY 3 cycles and RVALID 5 cycles -> ARVALID held stable, RREADY high only in R, one beat accepted. Streaming 8 words 0x1..0x8 gives in-order output.
5. Assert S_AXI_ARESETN=0 while in R and again while in PUSH -> ARVALID, RREADY, out_valid and busy go 0 asynchronously. After release the FSM is in IDLE and the next transaction is clean.
6. With AXI4_LITE_DRAIN_STATS_EN: 5 OKAY reads and 3 SLVERR reads -> stat_words=5, stat_errs=3.
